// File: rtl/shreg_serializer_ctrl.sv
// rtl/shreg_serializer_ctrl.sv - parallel-to-serial sequencer driving an N-bit universal shift register
// Optional trailing even-parity bit: SHREG_SER_PARITY_EN
module shreg_serializer_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         dir,
    input  logic         fill_bit,
    output logic [1:0]   selection,
    output logic [N-1:0] load_data,
    output logic         I_right,
    output logic         I_left,
    input  logic [N-1:0] reg_q,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         busy,
    output logic         done
);

`ifdef SHREG_SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, PAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;
`endif

    localparam logic [1:0]    SEL_HOLD = 2'b00;
    localparam logic [1:0]    SEL_LOAD = 2'b01;
    localparam logic [1:0]    SEL_SHL  = 2'b10;
    localparam logic [1:0]    SEL_SHR  = 2'b11;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  word_q;
    logic          dir_q;
    logic          fill_q;
    logic [N-1:0]  tap_mask;

    // One-hot tap on the register end that is about to leave
    assign tap_mask = dir_q ? N'(1) : {1'b1, {(N-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            word_q <= '0;
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && din_valid) begin
                word_q <= din;
                dir_q  <= dir;
                fill_q <= fill_bit;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        selection = SEL_HOLD;
        load_data = '0;
        I_right   = 1'b0;
        I_left    = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        din_ready = 1'b0;
        case (state)
            IDLE: begin
                din_ready = ~rst;
                if (din_valid) state_n = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                selection = SEL_LOAD;
                load_data = word_q;
                cnt_n     = '0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = |(reg_q & tap_mask);
                I_right   = fill_q;
                I_left    = fill_q;
                // Shifting only on acceptance keeps ser_out stable under backpressure
                if (ser_ready) begin
                    selection = dir_q ? SEL_SHR : SEL_SHL;
                    if (cnt == CNT_LAST) begin
`ifdef SHREG_SER_PARITY_EN
                        state_n = PAR;
`else
                        done    = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
`ifdef SHREG_SER_PARITY_EN
            PAR: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = ^word_q;
                I_right   = fill_q;
                I_left    = fill_q;
                if (ser_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shreg_serializer_ctrl.sv
// tb/tb_shreg_serializer_ctrl.sv - self-checking bench for shreg_serializer_ctrl with a shift register model
module tb_shreg_serializer_ctrl;
    localparam int N = 8;
`ifdef SHREG_SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         dir = 1'b0;
    logic         fill_bit = 1'b0;
    logic [1:0]   selection;
    logic [N-1:0] load_data;
    logic         I_right, I_left;
    logic [N-1:0] reg_q;
    logic         ser_out, ser_valid;
    logic         ser_ready = 1'b1;
    logic         busy, done;

    always #5 clk = ~clk;

    shreg_serializer_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dir(dir), .fill_bit(fill_bit), .selection(selection), .load_data(load_data),
        .I_right(I_right), .I_left(I_left), .reg_q(reg_q), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .busy(busy), .done(done)
    );

    // Downstream universal shift register
    logic [N-1:0] shreg;
    always @(posedge clk or posedge rst) begin
        if (rst) shreg <= '0;
        else case (selection)
            2'b01:   shreg <= load_data;
            2'b10:   shreg <= {shreg[N-2:0], I_right};
            2'b11:   shreg <= {I_left, shreg[N-1:1]};
            default: shreg <= shreg;
        endcase
    end
    assign reg_q = shreg;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 load, 2 streaming the expected bit list
    int           m_phase = 0;
    bit           m_bits[$];
    logic [N-1:0] m_word;
    bit           m_dir, m_fill;
    int           m_idx;
    logic [15:0]  cap = '0;
    int           ncap = 0;
    int           cyc = 0, accept_cyc = 0, done_cyc = 0;
    bit           done_seen = 1'b0;
    logic [1:0]   exp_sel;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_din_ready", din_ready, 0);
            check("rst_selection", selection, 0);
            check("rst_ser_valid", ser_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_load_data", load_data, 0);
            check("rst_fill_out", {I_right, I_left}, 0);
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin
                    check("idle_din_ready", din_ready, 1);
                    check("idle_selection", selection, 0);
                    check("idle_ser_valid", ser_valid, 0);
                    check("idle_busy", busy, 0);
                    check("idle_done", done, 0);
                    if (din_valid) begin
                        m_word = din; m_dir = dir; m_fill = fill_bit;
                        m_bits.delete();
                        for (int i = 0; i < N; i++) m_bits.push_back(dir ? din[i] : din[N-1-i]);
                        if (PB == 1) m_bits.push_back(^din);
                        m_phase = 1; accept_cyc = cyc; cap = '0; ncap = 0; done_seen = 1'b0;
                    end
                end
                1: begin
                    check("load_selection", selection, 1);
                    check("load_data", load_data, m_word);
                    check("load_busy", busy, 1);
                    check("load_din_ready", din_ready, 0);
                    check("load_ser_valid", ser_valid, 0);
                    check("load_done", done, 0);
                    m_phase = 2; m_idx = 0;
                end
                default: begin
                    exp_sel = !ser_ready ? 2'b00 : (m_idx < N ? (m_dir ? 2'b11 : 2'b10) : 2'b00);
                    check("sh_ser_valid", ser_valid, 1);
                    check("sh_busy", busy, 1);
                    check("sh_din_ready", din_ready, 0);
                    check("sh_ser_out", ser_out, m_bits[m_idx]);
                    check("sh_selection", selection, exp_sel);
                    check("sh_fill_out", {I_right, I_left}, {m_fill, m_fill});
                    check("sh_done", done, (ser_ready && m_idx == m_bits.size() - 1) ? 1 : 0);
                    if (ser_ready) begin
                        cap = {cap[14:0], ser_out};
                        ncap++;
                        if (m_idx == m_bits.size() - 1) m_phase = 0;
                        m_idx++;
                    end
                end
            endcase
        end
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc = cyc;
        end
        cyc++;
    end

    task automatic send(input logic [N-1:0] w, input bit d, input bit f);
        bit got = 1'b0;
        @(posedge clk); #1;
        din = w; dir = d; fill_bit = f; din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (din_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        din_valid = 1'b0; din = ~w; dir = ~d; fill_bit = ~f;
        check("accept_timeout", got, 1);
    endtask

    task automatic wait_ncap(input int k);
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (ncap >= k) begin got = 1'b1; break; end
        end
        check("ncap_timeout", got, 1);
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (done_seen) begin got = 1'b1; break; end
        end
        check("done_timeout", got, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("lit_idle_din_ready", din_ready, 1);
        check("lit_idle_selection", selection, 0);
        check("lit_idle_ser_valid", ser_valid, 0);
        check("lit_idle_busy", busy, 0);

        // MSB-first 0x1D, zero fill
        send(8'h1D, 1'b0, 1'b0);
        wait_done();
        check("w1_bits", cap[PB +: 8], 8'b0001_1101);
        check("w1_count", ncap, N + PB);
        check("w1_latency", done_cyc - accept_cyc, N + 1 + PB);
        if (PB == 1) check("w1_parity", cap[0], 0);

        // LSB-first 0x1D, one fill
        send(8'h1D, 1'b1, 1'b1);
        wait_done();
        check("w2_bits", cap[PB +: 8], 8'b1011_1000);
        check("w2_latency", done_cyc - accept_cyc, N + 1 + PB);
        @(posedge clk); #1;
        check("w2_reg_filled", reg_q, 8'hFF);

        // Three-cycle stall after four bits
        send(8'hA5, 1'b0, 1'b0);
        wait_ncap(4);
        @(posedge clk); #1 ser_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ser_ready = 1'b1;
        wait_done();
        check("stall_bits", cap[PB +: 8], 8'hA5);
        check("stall_latency", done_cyc - accept_cyc, N + 4 + PB);

        // din_valid toggling with 0xFF while busy
        send(8'h36, 1'b1, 1'b0);
        din = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1 din_valid = ~din_valid;
        end
        @(posedge clk); #1 din_valid = 1'b0;
        wait_done();
        check("busy_ignore_bits", cap[PB +: 8], 8'h6C);

`ifdef SHREG_SER_PARITY_EN
        send(8'h07, 1'b0, 1'b0);
        wait_done();
        check("par_bits", cap[8:0], 9'b0000_0111_1);
        check("par_count", ncap, 9);
`endif

        // Reset in the middle of a word
        send(8'hC3, 1'b0, 1'b0);
        wait_ncap(3);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_ser_valid", ser_valid, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("midrst_idle_ready", din_ready, 1);
        check("midrst_no_done", done_seen, 0);

        send(8'h1D, 1'b0, 1'b0);
        wait_done();
        check("recover_bits", cap[PB +: 8], 8'h1D);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
